// File: rtl/tile_reset_sequencer_if.sv
// Reset-sequencer channel bundle: soft-reset request/acknowledge plus the
// per-core resets and boot status seen by the tile wrapper.
interface tile_reset_sequencer_if #(
  parameter int NUM_CH = 2
);
  logic              spc_grst_l;
  logic [NUM_CH-1:0] soft_rst_req_i;
  logic [NUM_CH-1:0] soft_rst_ack_o;
  logic [NUM_CH-1:0] rst_n_o;
  logic              all_up_o;
  logic              boot_done_o;

  modport master (
    output soft_rst_req_i,
    input  spc_grst_l, soft_rst_ack_o, rst_n_o, all_up_o, boot_done_o
  );

  modport slave (
    input  soft_rst_req_i,
    output spc_grst_l, soft_rst_ack_o, rst_n_o, all_up_o, boot_done_o
  );
endinterface

// File: rtl/tile_reset_sequencer.sv
// Tile reset sequencer: reset synchroniser, wake-up delay, staggered core reset
// release and per-channel soft reset. Macro RST_SEQ_FAST_SIM_EN shortens the wake-up to 16 cycles.
module tile_reset_sequencer #(
  parameter int NUM_CH      = 2,
  parameter int CNT_WIDTH   = 16,
  parameter int STAGGER     = 64,
  parameter int SOFT_HOLD   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_l,
  tile_reset_sequencer_if.slave bus
);
  localparam int REL_LAST = (NUM_CH - 1) * STAGGER;
  localparam int CNT_MAX  = (NUM_CH * STAGGER > SOFT_HOLD) ? NUM_CH * STAGGER : SOFT_HOLD;
  localparam int CW       = $clog2(CNT_MAX + 1);
`ifdef RST_SEQ_FAST_SIM_EN
  localparam int WK_BIT = (CNT_WIDTH >= 5) ? 4 : CNT_WIDTH - 1;
`else
  localparam int WK_BIT = CNT_WIDTH - 1;
`endif

  typedef enum logic [1:0] {ST_WAKE, ST_RELEASE, ST_RUN} state_t;

  state_t                 state_reg, state_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rst_sync_n;
  logic [CNT_WIDTH-1:0]   wk_cnt_reg;
  logic [CW-1:0]          stg_cnt_reg, stg_cnt_next, stg_inc;
  logic [NUM_CH-1:0]      rst_n_reg, rst_n_next;
  logic [NUM_CH-1:0]      ack_reg, ack_next;
  logic                   all_up_reg, all_up_next;
  logic                   boot_done_reg, boot_done_next;
  logic                   spc_reg;
  logic [NUM_CH-1:0]      rel_first, rel_hit, hold_start, hold_zero;

  assign rst_sync_n = sync_reg[SYNC_STAGES-1];
  assign stg_inc    = stg_cnt_reg + CW'(1);

  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      sync_reg      <= '0;
      spc_reg       <= 1'b0;
      wk_cnt_reg    <= '0;
      state_reg     <= ST_WAKE;
      stg_cnt_reg   <= '0;
      rst_n_reg     <= '0;
      ack_reg       <= '0;
      all_up_reg    <= 1'b0;
      boot_done_reg <= 1'b0;
    end else begin
      sync_reg      <= {sync_reg[SYNC_STAGES-2:0], 1'b1};
      spc_reg       <= 1'b1;
      // Saturates as soon as the expiry bit sets.
      if (rst_sync_n && !wk_cnt_reg[WK_BIT])
        wk_cnt_reg <= wk_cnt_reg + CNT_WIDTH'(1);
      state_reg     <= state_next;
      stg_cnt_reg   <= stg_cnt_next;
      rst_n_reg     <= rst_n_next;
      ack_reg       <= ack_next;
      all_up_reg    <= all_up_next;
      boot_done_reg <= boot_done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    stg_cnt_next = stg_cnt_reg;
    rst_n_next   = rst_n_reg;
    ack_next     = '0;
    case (state_reg)
      ST_WAKE: begin
        if (wk_cnt_reg[WK_BIT]) begin
          state_next   = ST_RELEASE;
          stg_cnt_next = '0;
          rst_n_next   = rel_first;
        end
      end
      ST_RELEASE: begin
        if (stg_cnt_reg == CW'(REL_LAST)) begin
          state_next = ST_RUN;
        end else begin
          stg_cnt_next = stg_inc;
          rst_n_next   = rst_n_reg | rel_hit;
        end
      end
      ST_RUN: begin
        rst_n_next = (rst_n_reg & ~hold_start) | hold_zero;
        ack_next   = hold_zero;
      end
      default: state_next = ST_WAKE;
    endcase
    // Outputs follow the next state so they line up with the state change.
    all_up_next    = (state_next == ST_RUN) && (&rst_n_next);
    boot_done_next = boot_done_reg || (state_next == ST_RUN);
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CW-1:0] hold_reg;

    assign rel_first[gi]  = (gi * STAGGER == 0);
    assign rel_hit[gi]    = (stg_inc == CW'(gi * STAGGER));
    // A channel is in hold exactly when it is low while running.
    assign hold_start[gi] = (state_reg == ST_RUN) && rst_n_reg[gi] && bus.soft_rst_req_i[gi];
    assign hold_zero[gi]  = (state_reg == ST_RUN) && !rst_n_reg[gi] && (hold_reg == '0);

    always_ff @(posedge clk_i or negedge reset_l) begin
      if (!reset_l)
        hold_reg <= '0;
      else if (hold_start[gi])
        hold_reg <= CW'(SOFT_HOLD - 1);
      else if (hold_reg != '0)
        hold_reg <= hold_reg - CW'(1);
    end
  end

  assign bus.spc_grst_l     = spc_reg;
  assign bus.rst_n_o        = rst_n_reg;
  assign bus.soft_rst_ack_o = ack_reg;
  assign bus.all_up_o       = all_up_reg;
  assign bus.boot_done_o    = boot_done_reg;
endmodule

// File: tb/tb_tile_reset_sequencer.sv
// Bench for tile_reset_sequencer: two configurations (staggered and simultaneous
// release) checked every cycle against a timestamp-based reference model.
module tb_tile_reset_sequencer;
  localparam int CW_T = 6;
`ifdef RST_SEQ_FAST_SIM_EN
  localparam int WAKE = 16;
`else
  localparam int WAKE = 1 << (CW_T - 1);
`endif
  localparam int E0A = 2 + WAKE + 1;
  localparam int E0B = 3 + WAKE + 1;

  typedef struct {
    int         inst;
    int         edge_n;
    logic [7:0] rst;
    logic       up;
    logic       boot;
  } vec_t;

  logic        clk_i;
  logic        reset_l;
  logic [7:0]  req_v [2];
  logic [18:0] got_v [2];
  logic [18:0] exp_v [2];
  int          checks, failures, cnt, n;
  int          hs [2][8];
  vec_t        tbl [10];

  tile_reset_sequencer_if #(.NUM_CH(3)) if_a ();
  tile_reset_sequencer_if #(.NUM_CH(4)) if_b ();

  assign if_a.soft_rst_req_i = req_v[0][2:0];
  assign if_b.soft_rst_req_i = req_v[1][3:0];
  assign got_v[0] = {if_a.spc_grst_l, if_a.boot_done_o, if_a.all_up_o,
                     5'b0, if_a.soft_rst_ack_o, 5'b0, if_a.rst_n_o};
  assign got_v[1] = {if_b.spc_grst_l, if_b.boot_done_o, if_b.all_up_o,
                     4'b0, if_b.soft_rst_ack_o, 4'b0, if_b.rst_n_o};

  tile_reset_sequencer #(.NUM_CH(3), .CNT_WIDTH(CW_T), .STAGGER(5), .SOFT_HOLD(4), .SYNC_STAGES(2))
    dut_a (.clk_i(clk_i), .reset_l(reset_l), .bus(if_a));
  tile_reset_sequencer #(.NUM_CH(4), .CNT_WIDTH(CW_T), .STAGGER(0), .SOFT_HOLD(1), .SYNC_STAGES(3))
    dut_b (.clk_i(clk_i), .reset_l(reset_l), .bus(if_b));

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic int pn(int k);  return (k == 0) ? 3 : 4; endfunction
  function automatic int ps(int k);  return (k == 0) ? 5 : 0; endfunction
  function automatic int ph(int k);  return (k == 0) ? 4 : 1; endfunction
  function automatic int psy(int k); return (k == 0) ? 2 : 3; endfunction
  function automatic int e0(int k);  return psy(k) + WAKE + 1; endfunction
  function automatic int erun(int k); return e0(k) + (pn(k) - 1) * ps(k) + 1; endfunction

  // A channel is held low from its request edge for ph() edges.
  function automatic bit busy(int k, int i, int m);
    return hs[k][i] >= 0 && m >= hs[k][i] && m < hs[k][i] + ph(k);
  endfunction

  function automatic logic [18:0] model_out(int k);
    logic [7:0] r, a, mask;
    r    = '0;
    a    = '0;
    mask = 8'((1 << pn(k)) - 1);
    for (int i = 0; i < 8; i++) begin
      if (i < pn(k)) begin
        r[i] = (n >= e0(k) + i * ps(k)) && !busy(k, i, n);
        a[i] = (hs[k][i] >= 0) && (n == hs[k][i] + ph(k));
      end
    end
    return {(n >= 1), (n >= erun(k)), (n >= erun(k)) && (r == mask), a, r};
  endfunction

  // Reference model: n counts clock edges since reset_l release.
  initial begin
    n = 0;
    forever begin
      @(posedge clk_i);
      if (!reset_l) begin
        n = 0;
        for (int k = 0; k < 2; k++)
          for (int i = 0; i < 8; i++) hs[k][i] = -1;
      end else begin
        n = n + 1;
        for (int k = 0; k < 2; k++)
          for (int i = 0; i < 8; i++)
            if (i < pn(k) && n > erun(k) && !busy(k, i, n - 1) && req_v[k][i]) hs[k][i] = n;
      end
      for (int k = 0; k < 2; k++) exp_v[k] = model_out(k);
    end
  end

  task automatic check(string name, logic [18:0] got, logic [18:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%05h want=%05h", name, cnt, got, want);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    if (reset_l) cnt++;
    for (int k = 0; k < 2; k++) check($sformatf("model%0d", k), got_v[k], exp_v[k]);
  endtask

  task automatic do_reset(int len);
    reset_l = 1'b0;
    cnt     = 0;
    #1;
    for (int k = 0; k < 2; k++) check($sformatf("async_clr%0d", k), got_v[k], 19'h0);
    $display("reset asserted, outputs a=%05h b=%05h", got_v[0], got_v[1]);
    repeat (len) tick();
    reset_l = 1'b1;
  endtask

  task automatic run_table();
    req_v[1] = 8'h0F;
    for (int r = 0; r < 10; r++) begin
      while (cnt < tbl[r].edge_n) begin
        tick();
        if (cnt >= E0B) req_v[1] = 8'h00;
      end
      check($sformatf("boot_tbl%0d", r), got_v[tbl[r].inst],
            {1'b1, tbl[r].boot, tbl[r].up, 8'h00, tbl[r].rst});
      $display("boot inst=%0d edge=%0d rst=%b up=%b done=%b", tbl[r].inst, cnt,
               got_v[tbl[r].inst][7:0], got_v[tbl[r].inst][16], got_v[tbl[r].inst][17]);
    end
  endtask

  initial begin
    logic [18:0] want;
    int          acks[$];
    checks   = 0;
    failures = 0;
    cnt      = 0;
    reset_l  = 1'b0;
    req_v[0] = 8'h00;
    req_v[1] = 8'h00;
    tbl[0] = '{0, E0A - 1,  8'h00, 1'b0, 1'b0};
    tbl[1] = '{0, E0A,      8'h01, 1'b0, 1'b0};
    tbl[2] = '{1, E0B - 1,  8'h00, 1'b0, 1'b0};
    tbl[3] = '{1, E0B,      8'h0F, 1'b0, 1'b0};
    tbl[4] = '{1, E0B + 1,  8'h0F, 1'b1, 1'b1};
    tbl[5] = '{0, E0A + 4,  8'h01, 1'b0, 1'b0};
    tbl[6] = '{0, E0A + 5,  8'h03, 1'b0, 1'b0};
    tbl[7] = '{0, E0A + 9,  8'h03, 1'b0, 1'b0};
    tbl[8] = '{0, E0A + 10, 8'h07, 1'b0, 1'b0};
    tbl[9] = '{0, E0A + 11, 8'h07, 1'b1, 1'b1};

    repeat (3) tick();
    for (int k = 0; k < 2; k++) check($sformatf("reset_val%0d", k), got_v[k], 19'h0);
    reset_l = 1'b1;
    run_table();

    // Single soft-reset pulse on channel 1, re-pulsed mid-hold.
    req_v[0] = 8'h02;
    tick();
    req_v[0] = 8'h00;
    for (int j = 0; j <= 5; j++) begin
      if (j > 0) begin
        req_v[0] = (j == 2) ? 8'h02 : 8'h00;
        tick();
      end
      want = {1'b1, 1'b1, (j >= 4), 5'b0, (j == 4) ? 3'b010 : 3'b000,
              5'b0, (j < 4) ? 3'b101 : 3'b111};
      check($sformatf("soft_hold_j%0d", j), got_v[0], want);
      $display("soft j=%0d rst=%b ack=%b up=%b", j, got_v[0][2:0], got_v[0][10:8], got_v[0][16]);
    end

    // Both channels held requesting: back-to-back holds, acks every SOFT_HOLD+1.
    req_v[0] = 8'h03;
    for (int j = 0; j < 16; j++) begin
      tick();
      if (got_v[0][9:8] == 2'b11) acks.push_back(cnt);
    end
    req_v[0] = 8'h00;
    check("b2b_count", 19'(acks.size()), 19'd3);
    for (int i = 1; i < acks.size(); i++) begin
      check($sformatf("b2b_gap%0d", i), 19'(acks[i] - acks[i-1]), 19'd5);
      $display("b2b ack at %0d gap=%0d", acks[i], acks[i] - acks[i-1]);
    end
    repeat (6) tick();

    // Reset mid soft hold, then mid release; boot timing must repeat exactly.
    req_v[0] = 8'h01;
    tick();
    req_v[0] = 8'h00;
    repeat (2) tick();
    do_reset(2);
    run_table();
    while (cnt < E0A + 3) tick();
    do_reset(1);
    run_table();

    for (int it = 0; it < 1500; it++) begin
      for (int k = 0; k < 2; k++) req_v[k] = 8'($urandom) & 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 299) == 0) do_reset(int'($urandom_range(1, 3)));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
